// File: rtl/serial_rx_fsm.sv
// Start/data/stop serial receiver: two-flop input synchronizer, mid-bit sampling
// from a cycle-count bit timer, one-cycle valid / frame_err strobes.
module serial_rx_fsm #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             sync_q;
   logic                   rx_s;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   sh_q, sh_d;
   logic [DATA_BITS:0]     sh_in_s;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   busy_q, busy_d;

   assign rx_s    = sync_q[1];
   // New bit enters at the MSB so that after DATA_BITS shifts bit 0 sits at the LSB.
   assign sh_in_s = {rx_s, sh_q};

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxd};
      end
   end

   // Receiver state, timer, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, timer and strobe logic.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_s == 1'b0) begin
               state_d = START;
               tick_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick_q == TICK_HALF) begin
               tick_d = '0;
               bit_d  = '0;
               if (rx_s == 1'b0) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         DATA: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               sh_d   = sh_in_s[DATA_BITS:1];
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         STOP: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (rx_s == 1'b1) begin
                  data_d  = sh_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         BREAK: begin
            // A line stuck low must return high before another start is accepted.
            if (rx_s == 1'b1) begin
               state_d = IDLE;
            end else begin
               state_d = BREAK;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule
